// File: rtl/aes_ctr_sequencer.sv
// aes_ctr_sequencer
//   Drives aes_core in CTR mode as a streaming 128-bit encrypt/decrypt engine.
//   Each block: issue the counter block to the core, capture the keystream,
//   XOR it with one accepted input block into a one-entry output register.
//   The core key must already be loaded before start.
//
// Optional feature macro: AES_CTR_WRAP_ERR_EN
//   Defined   : a carry out of the low CTR_W counter bits sets sticky err_wrap;
//               the current block is still produced, then the run stops
//               without pulsing done.
//   Undefined : the counter wraps silently and err_wrap is tied to 0.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   start, abort        one-cycle control pulses
//   iv, num_blocks      initial counter block and run length (latched on start)
//   busy, done          FSM not idle; one-cycle run-complete pulse
//   err_wrap            sticky counter-wrap flag
//   in_data/valid/ready input stream (ready is combinational)
//   out_data/valid/ready output stream (registered)
//   core_*              aes_core handshake: plaintext, start/clear strobes,
//                       ready/busy/done status, ciphertext (keystream)
module aes_ctr_sequencer #(
    parameter int unsigned COUNT_W = 16,
    parameter int unsigned CTR_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [127:0]       iv,
    input  logic [COUNT_W-1:0] num_blocks,
    output logic               busy,
    output logic               done,
    output logic               err_wrap,
    input  logic [127:0]       in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [127:0]       out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       core_plaintext,
    output logic               core_encrypt_start,
    output logic               core_clear,
    input  logic               core_ready,
    input  logic               core_busy,
    input  logic               core_done,
    input  logic [127:0]       core_ciphertext
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_XOR
    } state_t;

    state_t             r_state;
    logic [127:0]       r_ctr;
    logic [127:0]       r_ks;
    logic [127:0]       r_out_data;
    logic [127:0]       r_core_pt;
    logic [COUNT_W-1:0] r_remaining;
    logic               r_out_valid;
    logic               r_done;
    logic               r_core_start;
    logic               r_core_clear;

    logic               w_in_ready;
    logic               w_in_fire;
    logic               w_out_fire;
    logic [127:0]       w_ctr_next;

    // Only the low CTR_W bits count; the upper bits are the fixed nonce.
    always_comb begin
        w_ctr_next              = r_ctr;
        w_ctr_next[CTR_W-1:0]   = r_ctr[CTR_W-1:0] + CTR_W'(1);
    end

    assign w_in_ready = (r_state == S_XOR) && (!r_out_valid || out_ready);
    assign w_in_fire  = w_in_ready && in_valid;
    assign w_out_fire = r_out_valid && out_ready;

`ifdef AES_CTR_WRAP_ERR_EN
    logic r_err_wrap;
    logic w_carry;
    assign w_carry  = &r_ctr[CTR_W-1:0];
    assign err_wrap = r_err_wrap;
`else
    assign err_wrap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ctr        <= '0;
            r_ks         <= '0;
            r_out_data   <= '0;
            r_core_pt    <= '0;
            r_remaining  <= '0;
            r_out_valid  <= 1'b0;
            r_done       <= 1'b0;
            r_core_start <= 1'b0;
            r_core_clear <= 1'b0;
`ifdef AES_CTR_WRAP_ERR_EN
            r_err_wrap   <= 1'b0;
`endif
        end else begin
            r_done       <= 1'b0;
            r_core_start <= 1'b0;
            r_core_clear <= 1'b0;

            // Drain happens first; an input handshake below may reload it.
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end

            if (abort && (r_state != S_IDLE)) begin
                r_state      <= S_IDLE;
                r_out_valid  <= 1'b0;
                r_core_clear <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // abort in idle is a no-op but still drops a coincident start
                        if (start && !abort) begin
`ifdef AES_CTR_WRAP_ERR_EN
                            r_err_wrap <= 1'b0;
`endif
                            if (num_blocks == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_ctr       <= iv;
                                r_remaining <= num_blocks;
                                r_state     <= S_ISSUE;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (core_ready && !core_busy) begin
                            r_core_pt    <= r_ctr;
                            r_core_start <= 1'b1;
                            r_state      <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (core_done) begin
                            r_ks    <= core_ciphertext;
                            r_state <= S_XOR;
                        end
                    end
                    S_XOR: begin
                        if (w_in_fire) begin
                            r_out_data  <= in_data ^ r_ks;
                            r_out_valid <= 1'b1;
                            r_ctr       <= w_ctr_next;
                            r_remaining <= r_remaining - COUNT_W'(1);
`ifdef AES_CTR_WRAP_ERR_EN
                            // A wrap ends the run even on the last block, without done.
                            if (w_carry) begin
                                r_err_wrap <= 1'b1;
                                r_state    <= S_IDLE;
                            end else
`endif
                            if (r_remaining == COUNT_W'(1)) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_ISSUE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy               = (r_state != S_IDLE);
    assign done               = r_done;
    assign in_ready           = w_in_ready;
    assign out_data           = r_out_data;
    assign out_valid          = r_out_valid;
    assign core_plaintext     = r_core_pt;
    assign core_encrypt_start = r_core_start;
    assign core_clear         = r_core_clear;

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
module tb_aes_ctr_sequencer;

    localparam int COUNT_W = 16;
    localparam int CTR_W   = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [127:0]       iv;
    logic [COUNT_W-1:0] num_blocks;
    logic               busy;
    logic               done;
    logic               err_wrap;
    logic [127:0]       in_data;
    logic               in_valid;
    logic               in_ready;
    logic [127:0]       out_data;
    logic               out_valid;
    logic               out_ready;
    logic [127:0]       core_plaintext;
    logic               core_encrypt_start;
    logic               core_clear;
    logic               core_ready;
    logic               core_busy;
    logic               core_done;
    logic [127:0]       core_ciphertext;

    always #5 clk = ~clk;

    aes_ctr_sequencer #(.COUNT_W(COUNT_W), .CTR_W(CTR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .iv(iv),
        .num_blocks(num_blocks), .busy(busy), .done(done), .err_wrap(err_wrap),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .core_plaintext(core_plaintext), .core_encrypt_start(core_encrypt_start),
        .core_clear(core_clear), .core_ready(core_ready), .core_busy(core_busy),
        .core_done(core_done), .core_ciphertext(core_ciphertext)
    );

    // Stand-in for aes_core: the two SP800-38A F.5.5 counter blocks map to
    // their real AES-256 keystream; anything else gets a fixed scrambling.
    function automatic logic [127:0] ks_fn(input logic [127:0] c);
        if (c == 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff) return 128'h0bdf7df1591716335e9a8b15c860c502;
        if (c == 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00) return 128'h5a6e699d536119065433863c8f657b94;
        return {c[95:0], c[127:96]} ^ {4{c[31:0] * 32'h9e3779b1}} ^ 128'hdeadbeef0badf00d12345678cafef00d;
    endfunction

    // k-th counter block of a run: low 32 bits count modulo 2^32.
    function automatic logic [127:0] ref_ctr(input logic [127:0] v, input int k);
        logic [31:0] lo;
        lo = v[31:0] + 32'(k);
        return {v[127:32], lo};
    endfunction

    // Core model: accepts a strobe, stays busy core_lat cycles, then pulses done.
    int unsigned  core_lat = 2;
    logic         m_active;
    int unsigned  m_cnt;
    logic [127:0] m_pt;
    logic [127:0] issued_q[$];

    always @(posedge clk) begin
        core_done <= 1'b0;
        if (rst) begin
            m_active        <= 1'b0;
            core_busy       <= 1'b0;
            m_cnt           <= 0;
            core_ciphertext <= '0;
        end else if (m_active) begin
            if (m_cnt == 0) begin
                m_active        <= 1'b0;
                core_busy       <= 1'b0;
                core_done       <= 1'b1;
                core_ciphertext <= ks_fn(m_pt);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (core_encrypt_start) begin
            m_active  <= 1'b1;
            core_busy <= 1'b1;
            m_cnt     <= core_lat;
            m_pt      <= core_plaintext;
            issued_q.push_back(core_plaintext);
        end
    end

    int done_cnt = 0, clear_cnt = 0, estart_cnt = 0;
    always @(negedge clk) begin
        if (done)               done_cnt++;
        if (core_clear)         clear_cnt++;
        if (core_encrypt_start) estart_cnt++;
    end

    int errors = 0, checks = 0;
    logic [127:0] src_q[$];
    logic [127:0] got_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] v, input int n);
        iv = v;
        num_blocks = COUNT_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feed src_q[sent0..n_in-1], collect outputs into got_q until the FSM is
    // idle and the output register has drained. poke_at >= 0 pulses start then.
    task automatic stream(input int n_in, input int sent0, input bit rnd, input int poke_at, input int max_cyc);
        int sent = sent0;
        int cyc = 0;
        bit fin = 0;
        bit timed_out = 0;
        in_valid  = (sent < n_in);
        in_data   = (sent < n_in) ? src_q[sent] : '0;
        out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        while (!fin) begin
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (!busy && !out_valid) fin = 1;
            else if (cyc >= max_cyc) begin
                fin = 1;
                timed_out = 1;
            end else begin
                tick();
                cyc++;
                start     = (cyc == poke_at);
                in_valid  = (sent < n_in) && (!rnd || $urandom_range(0, 3) != 0);
                in_data   = (sent < n_in) ? src_q[sent] : '0;
                out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (rnd) core_ready = ($urandom_range(0, 3) != 0);
            end
        end
        tick();
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; core_ready = 1'b1;
        check("stream_timeout", 128'(timed_out), 128'(0));
    endtask

    task automatic check_run(input string name, input logic [127:0] v, input int exp_outs,
                             input int exp_done, input bit exp_err, input int base, input int d0);
        logic [127:0] t;
        check({name, " n_out"}, 128'(got_q.size()), 128'(exp_outs));
        check({name, " n_issue"}, 128'(issued_q.size() - base), 128'(exp_outs));
        for (int k = 0; k < exp_outs; k++) begin
            t = (k < got_q.size()) ? got_q[k] : 'x;
            check($sformatf("%s out%0d", name, k), t, src_q[k] ^ ks_fn(ref_ctr(v, k)));
            t = (base + k < issued_q.size()) ? issued_q[base + k] : 'x;
            check($sformatf("%s ctr%0d", name, k), t, ref_ctr(v, k));
        end
        check({name, " done_pulses"}, 128'(done_cnt - d0), 128'(exp_done));
        check({name, " err_wrap"}, 128'(err_wrap), 128'(exp_err));
    endtask

    task automatic run_case(input string name, input logic [127:0] v, input int n, input int unsigned lat,
                            input bit rnd, input int poke_at, input int exp_outs, input int exp_done, input bit exp_err);
        int base, d0;
        core_lat = lat;
        src_q.delete();
        got_q.delete();
        for (int k = 0; k < n; k++) src_q.push_back({$urandom, $urandom, $urandom, $urandom});
        base = issued_q.size();
        d0 = done_cnt;
        do_start(v, n);
        if (poke_at >= 0) begin
            iv = ~v;
            num_blocks = COUNT_W'(7);
        end
        stream(n, 0, rnd, poke_at, 400 + 60 * n);
        check_run(name, v, exp_outs, exp_done, exp_err, base, d0);
    endtask

    // Run-level expectation straight from the counter rules.
    task automatic model_expect(input logic [127:0] v, input int n, output int eo, output int ed, output bit ee);
        eo = n; ed = 1; ee = 0;
`ifdef AES_CTR_WRAP_ERR_EN
        for (int k = 0; k < n; k++) begin
            if (v[31:0] + 32'(k) == 32'hffffffff) begin
                eo = k + 1; ed = 0; ee = 1;
                break;
            end
        end
`endif
    endtask

    typedef struct {
        logic [127:0] v_iv;
        int           n;
        int unsigned  lat;
        bit           rnd;
        int           exp_outs;
        int           exp_done;
        bit           exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent, cyc, bad, base, d0, c0, eo, ed;
        bit ee;
        logic [127:0] hold, v, t;

        vecs[0] = '{128'h00112233445566778899aabb00000010, 1, 0, 1'b0, 1, 1, 1'b0};
        vecs[1] = '{128'h0123456789abcdef0011223344556677, 4, 2, 1'b0, 4, 1, 1'b0};
        vecs[2] = '{128'h55555555aaaaaaaa5555555512345678, 0, 1, 1'b0, 0, 1, 1'b0};
`ifdef AES_CTR_WRAP_ERR_EN
        vecs[3] = '{128'hc0ffee00c0ffee00c0ffee00ffffffff, 3, 1, 1'b0, 1, 0, 1'b1};
        vecs[4] = '{128'h13579bdf2468ace013579bdffffffffe, 2, 0, 1'b0, 2, 0, 1'b1};
`else
        vecs[3] = '{128'hc0ffee00c0ffee00c0ffee00ffffffff, 3, 1, 1'b0, 3, 1, 1'b0};
        vecs[4] = '{128'h13579bdf2468ace013579bdffffffffe, 2, 0, 1'b0, 2, 1, 1'b0};
`endif
        vecs[5] = '{128'hfedcba98765432100f1e2d3c4b5a6978, 6, 3, 1'b1, 6, 1, 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; iv = '0; num_blocks = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1; core_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset ctrl", 128'({busy, done, err_wrap, in_ready, out_valid, core_encrypt_start, core_clear}), 128'(0));
        check("reset out_data", out_data, 128'(0));
        check("reset core_pt", core_plaintext, 128'(0));
        tick();
        rst = 1'b0;
        tick();

        // SP800-38A F.5.5 (CTR-AES256) first two blocks
        core_lat = 3;
        src_q = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51};
        got_q.delete();
        base = issued_q.size();
        d0 = done_cnt;
        do_start(128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 2);
        stream(2, 0, 1'b0, -1, 200);
        t = (got_q.size() > 0) ? got_q[0] : 'x;
        check("f55 out0", t, 128'h601ec313775789a5b7a7f504bbf3d228);
        t = (got_q.size() > 1) ? got_q[1] : 'x;
        check("f55 out1", t, 128'hf443e3ca4d62b59aca84e990cacaf5c5);
        t = (issued_q.size() > base) ? issued_q[base] : 'x;
        check("f55 ctr0_lo", 128'(t[31:0]), 128'(32'hfcfdfeff));
        t = (issued_q.size() > base + 1) ? issued_q[base + 1] : 'x;
        check("f55 ctr1_lo", 128'(t[31:0]), 128'(32'hfcfdff00));
        check("f55 done", 128'(done_cnt - d0), 128'(1));

        for (int i = 0; i < 6; i++) begin
            run_case($sformatf("vec%0d", i), vecs[i].v_iv, vecs[i].n, vecs[i].lat, vecs[i].rnd, -1,
                     vecs[i].exp_outs, vecs[i].exp_done, vecs[i].exp_err);
        end

        // num_blocks == 0: one-cycle done, never busy, no core strobe
        d0 = estart_cnt;
        do_start(128'h1, 0);
        @(negedge clk);
        check("zero done", 128'(done), 128'(1));
        check("zero busy", 128'(busy), 128'(0));
        tick();
        @(negedge clk);
        check("zero done_once", 128'(done), 128'(0));
        check("zero no_strobe", 128'(estart_cnt - d0), 128'(0));
        tick();

        // Backpressure: sink stalls 10 cycles after the first output
        core_lat = 1;
        src_q = '{128'h0f0e0d0c0b0a09080706050403020100, 128'h11112222333344445555666677778888};
        got_q.delete();
        base = issued_q.size();
        d0 = done_cnt;
        v = 128'ha5a5a5a5b6b6b6b6c7c7c7c700000100;
        out_ready = 1'b0; in_valid = 1'b1; in_data = src_q[0];
        do_start(v, 2);
        sent = 0; cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
            in_valid = (sent < 2);
            in_data  = (sent < 2) ? src_q[sent] : '0;
        end
        check("bp first_out", 128'(out_valid), 128'(1));
        hold = out_data;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready || !out_valid || out_data !== hold) bad++;
            tick();
        end
        check("bp hold", 128'(bad), 128'(0));
        stream(2, sent, 1'b0, -1, 200);
        check_run("bp", v, 2, 1, 1'b0, base, d0);

        // abort together with start in idle: start dropped
        d0 = done_cnt;
        iv = 128'h77; num_blocks = COUNT_W'(1); start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_start busy", 128'(busy), 128'(0));
        tick();

        // Abort in WAIT; the core's late done must be ignored
        core_lat = 6;
        d0 = done_cnt;
        c0 = clear_cnt;
        do_start(128'h9999999988888888777777776666aaaa, 2);
        cyc = 0;
        while (!core_busy && cyc < 20) begin
            tick();
            cyc++;
        end
        check("abort reach_wait", 128'(core_busy), 128'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort clear", 128'(core_clear), 128'(1));
        check("abort busy", 128'(busy), 128'(0));
        repeat (12) tick();
        check("abort stay_idle", 128'({busy, out_valid}), 128'(0));
        check("abort clear_once", 128'(clear_cnt - c0), 128'(1));
        check("abort no_done", 128'(done_cnt - d0), 128'(0));
        run_case("post_abort", 128'h4242424242424242424242420000abcd, 1, 2, 1'b0, -1, 1, 1, 1'b0);

        // start pulsed mid-run is ignored
        run_case("start_busy", 128'h31415926535897932384626400000042, 3, 2, 1'b0, 3, 3, 1, 1'b0);

        // rst while waiting in XOR with a stalled output
        core_lat = 0;
        src_q = '{128'hcafe, 128'hbeef};
        out_ready = 1'b0; in_valid = 1'b1; in_data = src_q[0];
        do_start(128'h2222222222222222222222220000000a, 4);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        in_data = src_q[1];
        repeat (6) tick();
        check("rst pre_busy", 128'({busy, out_valid}), 128'(3));
        out_ready = 1'b1; in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst ctrl", 128'({busy, done, err_wrap, in_ready, out_valid, core_encrypt_start, core_clear}), 128'(0));
        check("rst out_data", out_data, 128'(0));
        check("rst core_pt", core_plaintext, 128'(0));
        tick();
        run_case("post_rst", 128'h0badc0de0badc0de0badc0de00000000, 2, 1, 1'b0, -1, 2, 1, 1'b0);

        // Randomized runs against the run-level model
        for (int r = 0; r < 12; r++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 2) == 0) v[31:0] = 32'hffffffff - 32'($urandom_range(0, 4));
            sent = $urandom_range(1, 5);
            model_expect(v, sent, eo, ed, ee);
            run_case($sformatf("rnd%0d", r), v, sent, $urandom_range(0, 4), 1'b1, -1, eo, ed, ee);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
